// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register between processor stages.
// in_ready depends on registered state only, so ready never ripples upstream combinationally.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [15:0]         stall_q, stall_d;
   logic                accept, deliver;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         stall_q     <= '0;
      end else begin
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         stall_q     <= stall_d;
      end
   end

   assign accept  = in_valid && in_ready;
   assign deliver = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      stall_d     = (out_valid && !out_ready) ? sat_inc(stall_q) : stall_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d     = ONE;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (accept) begin
               state_d     = FULL;
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
            end else if (deliver) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (deliver) begin
               state_d     = ONE;
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
               skid_data_d = '0;
               skid_ctrl_d = '0;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush squashes control only; payload registers keep their last values.
      if (flush) begin
         state_d     = EMPTY;
         main_data_d = main_data_q;
         skid_data_d = skid_data_q;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end
   end

   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
      out_data  = main_data_q;
      out_ctrl  = out_valid ? main_ctrl_q : '0;
      stall_cnt = stall_q;
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, reset and
// saturation sequences, and a randomized run against a 2-deep FIFO scoreboard.
module tb_pipe_stage_reg;
   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, flush, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [15:0]   stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [DW-1:0] id;
      logic [CW-1:0] ic;
      logic          ordy;
      logic          fl;
      logic          ov;
      logic [DW-1:0] od;
      logic [CW-1:0] oc;
      logic          ir;
      logic [15:0]   sc;
   } vec_t;

   vec_t vecs[18];
   logic [CW+DW-1:0] sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                               input logic ordy, input logic fl, input logic ov,
                               input logic [DW-1:0] od, input logic [CW-1:0] oc,
                               input logic ir, input logic [15:0] sc);
      vec_t v;
      v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl;
      v.ov = ov; v.od = od; v.oc = oc; v.ir = ir; v.sc = sc;
      return v;
   endfunction

   task automatic drive(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                        input logic ordy, input logic fl);
      in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy; flush = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_ctrl"}, out_ctrl, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_stall_cnt"}, stall_cnt, 0);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      step();
      step();
      check_zero("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      int bad;
      logic [15:0] m_sc;
      logic        m_valid, m_ready, iv, ordy, fl;
      logic [DW-1:0] id;
      logic [CW-1:0] ic;

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      #2;
      check_zero("por");
      #20;
      step();
      do_reset();

      vecs[0]  = mk(1, 32'h1,  8'h05, 1, 0,  1, 32'h1,  8'h05, 1, 16'd0);
      vecs[1]  = mk(1, 32'h2,  8'h05, 1, 0,  1, 32'h2,  8'h05, 1, 16'd0);
      vecs[2]  = mk(1, 32'h3,  8'h05, 1, 0,  1, 32'h3,  8'h05, 1, 16'd0);
      vecs[3]  = mk(0, 32'h0,  8'h00, 1, 0,  0, 32'h3,  8'h00, 1, 16'd0);
      vecs[4]  = mk(1, 32'hAA, 8'h11, 0, 0,  1, 32'hAA, 8'h11, 1, 16'd0);
      vecs[5]  = mk(1, 32'hBB, 8'h22, 0, 0,  1, 32'hAA, 8'h11, 0, 16'd1);
      vecs[6]  = mk(0, 32'h0,  8'h00, 0, 0,  1, 32'hAA, 8'h11, 0, 16'd2);
      vecs[7]  = mk(0, 32'h0,  8'h00, 1, 0,  1, 32'hBB, 8'h22, 1, 16'd2);
      vecs[8]  = mk(0, 32'h0,  8'h00, 1, 0,  0, 32'hBB, 8'h00, 1, 16'd2);
      vecs[9]  = mk(1, 32'hD0, 8'h33, 0, 0,  1, 32'hD0, 8'h33, 1, 16'd2);
      vecs[10] = mk(1, 32'hE0, 8'h44, 0, 0,  1, 32'hD0, 8'h33, 0, 16'd3);
      vecs[11] = mk(1, 32'hC0, 8'h55, 0, 1,  0, 32'hD0, 8'h00, 1, 16'd4);
      vecs[12] = mk(1, 32'h11, 8'h66, 0, 0,  1, 32'h11, 8'h66, 1, 16'd4);
      vecs[13] = mk(1, 32'hC1, 8'h77, 1, 1,  0, 32'h11, 8'h00, 1, 16'd4);
      vecs[14] = mk(0, 32'h0,  8'h00, 1, 0,  0, 32'h11, 8'h00, 1, 16'd4);
      vecs[15] = mk(1, 32'h21, 8'h01, 1, 0,  1, 32'h21, 8'h01, 1, 16'd4);
      vecs[16] = mk(1, 32'h22, 8'h02, 1, 0,  1, 32'h22, 8'h02, 1, 16'd4);
      vecs[17] = mk(0, 32'h0,  8'h00, 1, 0,  0, 32'h22, 8'h00, 1, 16'd4);

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy, vecs[i].fl);
         step();
         chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
         chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
         chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, vecs[i].oc);
         chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].ir);
         chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].sc);
      end

      // Asynchronous reset while FULL, then activity under reset, then recovery.
      drive(1, 32'hAB, 8'h0A, 0, 0);
      step();
      drive(1, 32'hCD, 8'h0B, 0, 0);
      step();
      chk("pre_areset_in_ready", in_ready, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("areset");
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h1234 + i, 8'hFF, i[0], i[1]);
         step();
         check_zero("in_reset");
      end
      rst_n = 1'b1;
      drive(1, 32'h5A, 8'h09, 0, 0);
      step();
      chk("post_reset_out_valid", out_valid, 1);
      chk("post_reset_out_data", out_data, 32'h5A);
      chk("post_reset_out_ctrl", out_ctrl, 8'h09);
      chk("post_reset_in_ready", in_ready, 1);

      // Stall counter saturation.
      do_reset();
      drive(1, 32'hDEADBEEF, 8'h0F, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      bad = 0;
      for (int i = 0; i < 70000; i++) begin
         step();
         if (out_data !== 32'hDEADBEEF || out_valid !== 1'b1) bad++;
      end
      chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
      chk("sat_data_stable", bad, 0);
      for (int i = 0; i < 5; i++) step();
      chk("sat_stall_hold", stall_cnt, 16'hFFFF);
      chk("sat_out_data", out_data, 32'hDEADBEEF);

      // Randomized traffic against a 2-deep FIFO scoreboard.
      do_reset();
      sb.delete();
      m_sc = 16'd0;
      for (int i = 0; i < 3000; i++) begin
         iv   = ($urandom_range(99) < 60);
         ordy = ($urandom_range(99) < 55);
         fl   = ($urandom_range(99) < 2);
         id   = $urandom;
         ic   = $urandom_range(255);
         drive(iv, id, ic, ordy, fl);
         m_ready = (sb.size() < 2);
         m_valid = (sb.size() > 0);
         chk("rnd_in_ready", in_ready, m_ready);
         if (m_valid && !ordy && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
         if (fl) begin
            sb.delete();
         end else begin
            if (m_valid && ordy) void'(sb.pop_front());
            if (iv && m_ready) sb.push_back({ic, id});
         end
         step();
         chk("rnd_out_valid", out_valid, sb.size() > 0);
         if (sb.size() > 0) begin
            chk("rnd_out_data", out_data, sb[0][DW-1:0]);
            chk("rnd_out_ctrl", out_ctrl, sb[0][CW+DW-1:DW]);
         end else begin
            chk("rnd_out_ctrl_bubble", out_ctrl, 0);
         end
         chk("rnd_stall_cnt", stall_cnt, m_sc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width (ALU result, PC, write-reg bundle).
REQ-002 SHALL have parameter CTRL_W, default 8: control-bit width (MemtoReg, RegWrite, DataC, ...); all-zero means a bubble.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: upstream stage presents an instruction.
REQ-006 SHALL have port in_ready, output, 1: block accepts this cycle.
REQ-007 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-008 SHALL have port in_ctrl, input, CTRL_W: upstream control bits.
REQ-009 SHALL have port flush, input, 1: synchronous squash of all held entries.
REQ-010 SHALL have port out_valid, output, 1: instruction presented downstream.
REQ-011 SHALL have port out_ready, input, 1: downstream consumes this cycle.
REQ-012 SHALL have port out_data, output, DATA_W: head payload.
REQ-013 SHALL have port out_ctrl, output, CTRL_W: head control; zero whenever out_valid=0.
REQ-014 SHALL have port stall_cnt, output, 16: saturating count of backpressure cycles.

Function
REQ-015 SHALL hold up to two entries (main, skid) in FIFO order; states EMPTY, ONE, FULL.
REQ-016 SHALL drive in_ready = (state != FULL), decoded from registered state only; no combinational path from out_ready.
REQ-017 SHALL accept when in_valid && in_ready and deliver when out_valid && out_ready.
REQ-018 SHALL drive out_valid = (state != EMPTY) and out_data/out_ctrl from main.
REQ-019 SHALL have latency 1: an entry accepted at edge N appears on outputs after edge N when the block was EMPTY.
REQ-020 EMPTY: accept -> ONE, main loaded.
REQ-021 ONE: accept and deliver -> ONE, main replaced by input; accept only -> FULL, skid loaded; deliver only -> EMPTY; neither -> ONE, hold.
REQ-022 FULL: deliver -> ONE, main loaded from skid, skid cleared; no deliver -> FULL, hold.
REQ-023 SHALL keep main and skid stable while not delivered; no entry is dropped or duplicated.
REQ-024 flush=1 at an edge SHALL force EMPTY and zero main and skid ctrl, overriding any accept or deliver in that cycle; the accepted input is discarded.
REQ-025 flush SHALL leave data registers holding their last values; only ctrl and state are cleared.
REQ-026 stall_cnt SHALL increment by 1 each edge with out_valid=1 and out_ready=0, saturate at 16'hFFFF, and be unaffected by flush.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, set state EMPTY, out_valid=0, in_ready=1, main/skid data and ctrl=0, out_data=0, out_ctrl=0, stall_cnt=0.
REQ-028 Reset asserted mid-operation SHALL discard held entries; the first accept after deassertion follows REQ-020.
REQ-029 SHALL leave all outputs stable while rst_n=0 regardless of the other inputs.

Verification
REQ-030 Streaming: out_ready=1; in_valid=1 with data 1,2,3 and ctrl 8'h05 on consecutive cycles -> out_data 1,2,3 one cycle later; in_ready stays 1; stall_cnt=0.
REQ-031 Backpressure: in data A then B with out_ready=0 -> after B, in_ready=0 and out_data=A; raise out_ready -> A then B delivered in order; stall_cnt=2 after the two held cycles.
REQ-032 Flush while FULL, in_valid=1 data C -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears on the outputs.
REQ-033 Async reset: drop rst_n between clock edges while FULL -> outputs zero and in_ready=1 before the next edge.
REQ-034 Saturation: out_valid=1, out_ready=0 held for 70000 cycles -> stall_cnt=16'hFFFF and stays there; out_data unchanged throughout.
REQ-035 Random valid/ready with flush at 2% rate, checked against a 2-deep reference FIFO model -> no mismatches, loss, or duplication.
